zeroriscy_md_seq: RTL

ZERORISCY_MD_SEQ -- requirements
Module: zeroriscy_md_seq

---
 rtl/zeroriscy_md_seq_if.sv | 23 ++
 rtl/zeroriscy_md_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_md_seq_if.sv
// Request/response bundle between the core and the iterative multiply/divide unit.
// The core side uses the master modport; the unit uses the slave modport.
interface zeroriscy_md_seq_if;
  logic        md_en_i;
  logic [1:0]  md_operator_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        kill_i;
  logic [31:0] md_result_o;
  logic        ready_o;
  logic        busy_o;

  modport master (
    output md_en_i, md_operator_i, signed_mode_i, op_a_i, op_b_i, kill_i,
    input  md_result_o, ready_o, busy_o
  );

  modport slave (
    input  md_en_i, md_operator_i, signed_mode_i, op_a_i, op_b_i, kill_i,
    output md_result_o, ready_o, busy_o
  );
endinterface

// File: rtl/zeroriscy_md_seq.sv
// Iterative RV32M multiply/divide unit: sign-magnitude conversion, 32 radix-2 steps
// (shift-add multiply or restoring divide), then sign fix-up, at a fixed 34-cycle latency.
module zeroriscy_md_seq (
  input  logic              clk,
  input  logic              rst_n,
  zeroriscy_md_seq_if.slave md
);
  typedef enum logic [1:0] {IDLE = 2'b00, ABS = 2'b01, ITER = 2'b10, FIX = 2'b11} state_e;

  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d, smode_q, smode_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [32:0] rem_q, rem_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;

  logic        start_s, is_div_s, sign_a_s, sign_b_s, div_zero_s, ready_s, busy_s;
  logic [31:0] abs_a_s, abs_b_s, addend_s, quo_s, rem_fix_s, fix_result_s, result_out_s;
  logic [32:0] sum_s;
  logic [33:0] shifted_s, diff_s;
  logic [63:0] prod_s;

  assign start_s    = md.md_en_i & ~md.kill_i;
  assign is_div_s   = op_q[1];
  assign sign_a_s   = smode_q[0] & a_q[31];
  assign sign_b_s   = smode_q[1] & b_q[31];
  assign abs_a_s    = sign_a_s ? (32'd0 - a_q) : a_q;
  assign abs_b_s    = sign_b_s ? (32'd0 - b_q) : b_q;
  assign div_zero_s = is_div_s & (b_q == 32'd0);

  // During ITER b_q holds the multiplicand (multiply) or divisor magnitude (divide).
  assign addend_s   = acc_q[0] ? b_q : 32'd0;
  assign sum_s      = {1'b0, acc_q[63:32]} + {1'b0, addend_s};
  assign shifted_s  = {rem_q, acc_q[31]};
  assign diff_s     = shifted_s - {2'b00, b_q};

  assign prod_s     = neg_q ? (64'd0 - acc_q) : acc_q;
  assign quo_s      = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix_s  = neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

  // Final result selection after sign fix-up
  always_comb begin
    fix_result_s = 32'd0;
    case (op_q)
      MD_OP_MULL: fix_result_s = prod_s[31:0];
      MD_OP_MULH: fix_result_s = prod_s[63:32];
      MD_OP_DIV:  fix_result_s = quo_s;
      MD_OP_REM:  fix_result_s = rem_fix_s;
      default:    fix_result_s = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill aborts from any busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_s) state_d = ABS; else state_d = IDLE;
      ABS:  if (md.kill_i) state_d = IDLE; else state_d = ITER;
      ITER: begin
        if (md.kill_i) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd0) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; a kill in FIX swallows the completion pulse
  always_comb begin
    busy_s = (state_q != IDLE);
    if ((state_q == FIX) && !md.kill_i) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if (state_q == FIX) begin
      result_out_s = fix_result_s;
    end else begin
      result_out_s = result_q;
    end
  end

  assign md.ready_o     = ready_s;
  assign md.busy_o      = busy_s;
  assign md.md_result_o = result_out_s;

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    smode_d  = smode_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          op_d    = md.md_operator_i;
          smode_d = md.signed_mode_i;
          a_d     = md.op_a_i;
          b_d     = md.op_b_i;
        end else begin
          op_d    = op_q;
        end
      end
      ABS: begin
        b_d   = is_div_s ? abs_b_s : abs_a_s;
        acc_d = is_div_s ? {32'd0, abs_a_s} : {32'd0, abs_b_s};
        rem_d = 33'd0;
        cnt_d = 6'd31;
        // Remainder sign follows the dividend; a zero divisor must keep DIV at all-ones.
        if (op_q == MD_OP_REM) begin
          neg_d = sign_a_s;
        end else if (div_zero_s) begin
          neg_d = 1'b0;
        end else begin
          neg_d = sign_a_s ^ sign_b_s;
        end
      end
      ITER: begin
        if (is_div_s) begin
          rem_d = diff_s[33] ? shifted_s[32:0] : diff_s[32:0];
          acc_d = {32'd0, acc_q[30:0], ~diff_s[33]};
        end else begin
          acc_d = {sum_s, acc_q[31:1]};
        end
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          cnt_d = 6'd0;
        end
      end
      FIX: begin
        if (!md.kill_i) begin
          result_d = fix_result_s;
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        cnt_d = 6'd0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      smode_q  <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      op_q     <= op_d;
      smode_q  <= smode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
endmodule
